if_fetch_unit: RTL
==================

// Module: if_fetch_unit
// PURPOSE
//  Instruction-fetch stage: owns the PC and issues requests to instruction memory.
//  It is the producer side of the IF/ID register. It drives PCAdder_out, Instruction_out
//  and IFID_flush, which are consumed by the IF/ID pipeline register.
//  Applies stalls from the hazard unit and branch/jump redirects from later stages.
//  A one-entry skid buffer absorbs memory returns that arrive during a stall.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset; address of the first fetch
//  PC_W      32             PC/address width; only 32 is supported
// PORTS
//  Clk              in   1   clock; all state updates on posedge
//  Rst              in   1   reset, asynchronous, active-low (0 = reset)
//  Stall            in   1   hazard unit: hold IF/ID outputs and PC this cycle
//  Redirect         in   1   branch/jump resolved taken; wins over Stall
//  RedirectTarget   in   32  new PC; bits [1:0] ignored (forced to 0)
//  imem_req         out  1   instruction-memory request valid
//  imem_addr        out  32  request address, word aligned
//  imem_ack         in   1   memory returns imem_rdata for the held request this cycle
//  imem_rdata       in   32  instruction word, valid only when imem_ack=1
//  PCAdder_out      out  32  PC+4 of the instruction on Instruction_out
//  Instruction_out  out  32  fetched instruction (NOP 32'h0 when invalid)
//  FetchValid       out  1   Instruction_out/PCAdder_out carry a real instruction
//  IFID_flush       out  1   1-cycle pulse: wrong-path instruction must be killed
//  PC_out           out  32  current fetch PC (debug/trace)
// BEHAVIOUR
//  Reset (Rst=0, asynchronous, immediate):
//  - imem_req=0, imem_addr=RESET_PC, PC_out=RESET_PC.
//  - PCAdder_out=0, Instruction_out=0, FetchValid=0, IFID_flush=0.
//  - Skid buffer empty; drop flag cleared; state=S_IDLE.
//  Reset asserted mid-request abandons the request; memory must tolerate this.
//  State machine:
//  - S_IDLE: first cycle after reset release -> S_REQ.
//  - S_REQ: imem_req=1, imem_addr=PC. The address is held stable until imem_ack.
//    An ack in the first cycle is legal.
//  - S_HOLD: Stall=1 and the skid buffer is full. imem_req=0; wait.
//  - S_DRAIN: redirect was taken while a request was outstanding. Keep req/addr
//    until ack, discard the returned data, then -> S_REQ at the new PC.
//  Normal ack (no Stall, no Redirect):
//  - Instruction_out<=imem_rdata, PCAdder_out<=PC+4, FetchValid<=1, PC<=PC+4.
//  - Re-request at the new PC the next cycle; sustained throughput is 1 instr/cycle.
//  - Latency: posedge with ack -> outputs valid after that edge.
//  No ack: FetchValid<=0 and Instruction_out<=NOP. The ID stage sees a bubble.
//  Stall=1:
//  - Outputs and PC hold.
//  - An outstanding request is not withdrawn. Its ack data goes to the skid buffer
//    (with PC+4), PC advances, and the state goes to S_HOLD.
//  - No new request is issued while the buffer is full.
//  Stall release:
//  - Buffer non-empty: present the buffer contents that cycle, empty it, -> S_REQ.
//  - Buffer empty: resume S_REQ.
//  Redirect=1 (highest priority, any state):
//  - PC<={RedirectTarget[31:2],2'b00}.
//  - IFID_flush<=1 for exactly one cycle; FetchValid<=0, Instruction_out<=NOP.
//  - Skid buffer cleared.
//  - Request outstanding and no ack this cycle -> S_DRAIN.
//  - Ack in the same cycle -> its data is dropped and the state goes to S_REQ.
//  Simultaneous events:
//  - Redirect+Stall: redirect wins, and the PC still updates.
//  - Redirect in S_DRAIN: the target is replaced by the newest one.
//  Arithmetic: PC+4 is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0 with no error.
// STRUCTURE
//  Shared package cpu_pkg:
//  - NOP_INSTR=32'h0, PC_INC=32'd4.
//  - Fetch state encodings S_IDLE/S_REQ/S_HOLD/S_DRAIN (localparams).
//  Sub-module fetch_skid_buf: one-entry {instr,pcadd} register with load/clear/full.
//  The remaining logic is the FSM plus the PC register.
// TESTING
//  1 Reset release, imem_ack every cycle with rdata=addr -> addrs 0,4,8,12.
//    PCAdder_out 4,8,12 and FetchValid=1 from the 2nd cycle onward.
//  2 Ack delayed 3 cycles at PC=8 -> imem_addr held at 8 with req=1.
//    FetchValid=0 for 3 cycles, then Instruction_out=8 and PCAdder_out=12.
//  3 Stall=1 for 4 cycles, ack arrives in stall cycle 1 (rdata=0xAA) -> outputs frozen
//    and req=0 after the ack. On release: Instruction_out=0xAA, then a fetch from PC+4.
//  4 Redirect to 0x103 while the request at 0x20 is outstanding -> IFID_flush=1 for one cycle.
//    The 0x20 data is dropped on ack; the next imem_addr is 0x100.
//  5 Redirect+Stall in the same cycle with a full buffer -> buffer cleared and flush pulse.
//    The next fetch goes to the target.
//  6 RESET_PC=0xFFFF_FFFC -> first PCAdder_out=0; then Rst=0 mid-wait gives all
//    reset values immediately.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: constants, fetch-state encodings, skid entry type.
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_INC    = 32'd4;
  localparam logic [XLEN-1:0] WORD_MASK = 32'h0000_0003;

  // Fetch FSM encodings, kept as plain constants so other blocks can decode them.
  localparam logic [1:0] S_IDLE_ENC  = 2'd0;
  localparam logic [1:0] S_REQ_ENC   = 2'd1;
  localparam logic [1:0] S_HOLD_ENC  = 2'd2;
  localparam logic [1:0] S_DRAIN_ENC = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = S_IDLE_ENC,
    S_REQ   = S_REQ_ENC,
    S_HOLD  = S_HOLD_ENC,
    S_DRAIN = S_DRAIN_ENC
  } fetch_state_e;

  // One fetched instruction together with the PC+4 that travels with it.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pcadd;
  } fetch_entry_t;

  // Force an address onto a word boundary.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return addr & ~WORD_MASK;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer that parks a memory return arriving during a stall.
module fetch_skid_buf
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         clear_i,
  input  fetch_entry_t entry_i,
  output fetch_entry_t entry_o,
  output logic         full_o
);

  fetch_entry_t entry_q;
  logic         full_q;

  // Capture on load, empty on clear; clear wins if both are raised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the payload is reset along with the full flag so entry_o is never X after reset.
      entry_q <= '0;
      full_q  <= 1'b0;
    end else if (clear_i) begin
      // NOTE: non-blocking updates so every flop here samples pre-edge values.
      full_q  <= 1'b0;
    end else if (load_i) begin
      entry_q <= entry_i;
      full_q  <= 1'b1;
    end
  end

  assign entry_o = entry_q;
  assign full_o  = full_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, imem request FSM, IF/ID-facing outputs.
// Only a 32-bit PC is supported.
module if_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_W     = 32
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            Stall,
  input  logic            Redirect,
  input  logic [PC_W-1:0] RedirectTarget,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [PC_W-1:0] PCAdder_out,
  output logic [31:0]     Instruction_out,
  output logic            FetchValid,
  output logic            IFID_flush,
  output logic [PC_W-1:0] PC_out
);

  fetch_state_e    state_q;
  logic [PC_W-1:0] pc_q;
  logic            req_q;
  logic [PC_W-1:0] addr_q;   // address of the request currently on the bus
  logic [PC_W-1:0] pcadd_q;
  logic [31:0]     instr_q;
  logic            valid_q;
  logic            flush_q;

  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] redirect_pc;

  fetch_entry_t skid_in;
  fetch_entry_t skid_out;
  logic         skid_full;
  logic         skid_load;
  logic         skid_clear;

  assign pc_plus4    = pc_q + PC_INC;   // wraps modulo 2^32 by construction
  assign redirect_pc = align_word(RedirectTarget);

  // A return that lands while stalled is parked; a redirect or stall release empties it.
  assign skid_in    = '{instr: imem_rdata, pcadd: pc_plus4};
  assign skid_load  = (state_q == S_REQ) && imem_ack && Stall && !Redirect;
  assign skid_clear = Redirect || ((state_q == S_HOLD) && !Stall);

  fetch_skid_buf u_skid (
    .clk     (Clk),
    .rst_n   (Rst),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .entry_i (skid_in),
    .entry_o (skid_out),
    .full_o  (skid_full)
  );

  // Fetch FSM, PC register and the registered IF/ID-facing outputs.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      pcadd_q <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      flush_q <= 1'b0;
      if (Redirect) begin
        // Redirect beats everything, including Stall; the current output is wrong-path.
        pc_q    <= redirect_pc;
        flush_q <= 1'b1;
        valid_q <= 1'b0;
        instr_q <= NOP_INSTR;
        req_q   <= 1'b1;
        if (req_q && !imem_ack) begin
          // The in-flight request must still complete; addr_q keeps its address.
          state_q <= S_DRAIN;
        end else begin
          state_q <= S_REQ;
          addr_q  <= redirect_pc;
        end
      end else begin
        unique case (state_q)
          S_IDLE: begin
            state_q <= S_REQ;
            req_q   <= 1'b1;
            addr_q  <= pc_q;
          end
          S_REQ: begin
            if (imem_ack) begin
              pc_q   <= pc_plus4;
              addr_q <= pc_plus4;
              if (Stall) begin
                // Data went into the skid buffer; stop requesting until release.
                state_q <= S_HOLD;
                req_q   <= 1'b0;
              end else begin
                instr_q <= imem_rdata;
                pcadd_q <= pc_plus4;
                valid_q <= 1'b1;
              end
            end else if (!Stall) begin
              // Nothing returned: hand ID a bubble.
              instr_q <= NOP_INSTR;
              valid_q <= 1'b0;
            end
          end
          S_HOLD: begin
            if (!Stall) begin
              if (skid_full) begin
                instr_q <= skid_out.instr;
                pcadd_q <= skid_out.pcadd;
                valid_q <= 1'b1;
              end else begin
                instr_q <= NOP_INSTR;
                valid_q <= 1'b0;
              end
              state_q <= S_REQ;
              req_q   <= 1'b1;
              addr_q  <= pc_q;
            end
          end
          S_DRAIN: begin
            // Swallow the stale return, then fetch from the redirect target.
            if (imem_ack) begin
              state_q <= S_REQ;
              addr_q  <= pc_q;
            end
          end
          default: begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign imem_req        = req_q;
  assign imem_addr       = addr_q;
  assign PCAdder_out     = pcadd_q;
  assign Instruction_out = instr_q;
  assign FetchValid      = valid_q;
  assign IFID_flush      = flush_q;
  assign PC_out          = pc_q;

endmodule
